// File: rtl/fp_calc_sequencer.sv
// fp_calc_sequencer
// Accepts one floating-point request at a time, launches it on a shared FP
// unit and returns the unit's answer. Illegal opcodes complete at once with
// an error code. A watchdog aborts requests the unit never answers.
//
// Optional feature macro: FP_SEQ_NAN_BYPASS_EN
//   When defined, a request with a NaN operand completes at once with the
//   error code and is never sent to the unit (in2 is not checked for sq).
//   When undefined, NaN operands are sent to the unit like any other value.
module fp_calc_sequencer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        unit_start,
    output logic [2:0]  unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic        unit_done,
    input  logic [31:0] unit_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        err,
    output logic        timeout
);

    typedef enum logic [1:0] {
        s_idle,
        s_issue,
        s_wait,
        s_done
    } state_t;

    localparam logic [2:0]  op_add   = 3'b000;
    localparam logic [2:0]  op_mult  = 3'b001;
    localparam logic [2:0]  op_div   = 3'b010;
    localparam logic [2:0]  op_nroot = 3'b011;
    localparam logic [2:0]  op_sq    = 3'b100;

    // Value returned whenever the unit did not produce the answer.
    localparam logic [31:0] err_result = 32'h7FFF_FFFF;

    // Watchdog terminal count; the counter is 8 bits wide, matching the
    // legal 1..255 range of TIMEOUT_CYC.
    localparam logic [7:0]  timeout_term = 8'(TIMEOUT_CYC);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_inc;
    logic        op_legal;
    logic        nan_bypass;

    // Only the five defined opcodes are sent to the unit.
    always_comb begin
        op_legal = 1'b0;
        case (op)
            op_add, op_mult, op_div, op_nroot, op_sq: op_legal = 1'b1;
            default:                                  op_legal = 1'b0;
        endcase
    end

`ifdef FP_SEQ_NAN_BYPASS_EN
    // A NaN has an all-ones exponent and a non-zero fraction.
    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Short-circuit NaN requests; sq has no second operand to inspect.
    always_comb begin
        nan_bypass = 1'b0;
        if (is_nan(in1))
            nan_bypass = 1'b1;
        else if ((op != op_sq) && is_nan(in2))
            nan_bypass = 1'b1;
    end
`else
    // NaN operands take the normal path to the unit.
    always_comb begin
        nan_bypass = 1'b0;
    end
`endif

    // The watchdog terminal test looks at the value the counter is about to
    // take, so exactly TIMEOUT_CYC WAIT cycles elapse before the abort.
    always_comb begin
        wait_cnt_inc = wait_cnt + 8'd1;
    end

    // Sequencer FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= s_idle;
            wait_cnt   <= 8'd0;
            unit_start <= 1'b0;
            unit_op    <= 3'd0;
            unit_a     <= 32'd0;
            unit_b     <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 32'd0;
            err        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            unit_start <= 1'b0;
            done       <= 1'b0;

            case (state)
                s_idle: begin
                    if (start) begin
                        unit_op <= op;
                        unit_a  <= in1;
                        unit_b  <= in2;
                        err     <= 1'b0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                        if (!op_legal) begin
                            state  <= s_done;
                            done   <= 1'b1;
                            result <= err_result;
                            err    <= 1'b1;
                        end else if (nan_bypass) begin
                            state  <= s_done;
                            done   <= 1'b1;
                            result <= err_result;
                        end else begin
                            state      <= s_issue;
                            unit_start <= 1'b1;
                        end
                    end
                end

                s_issue: begin
                    wait_cnt <= 8'd0;
                    state    <= s_wait;
                end

                s_wait: begin
                    if (unit_done) begin
                        result <= unit_result;
                        done   <= 1'b1;
                        state  <= s_done;
                    end else if (wait_cnt_inc == timeout_term) begin
                        wait_cnt <= wait_cnt_inc;
                        result   <= err_result;
                        timeout  <= 1'b1;
                        done     <= 1'b1;
                        state    <= s_done;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                    end
                end

                s_done: begin
                    busy  <= 1'b0;
                    state <= s_idle;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= s_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_calc_sequencer.sv
// Directed testbench for fp_calc_sequencer (watchdog set to 4 cycles).
// The bench plays the role of the shared FP unit.
module tb_fp_calc_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        unit_start;
    logic [2:0]  unit_op;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        unit_done;
    logic [31:0] unit_result;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;
    logic        timeout;

    int checks = 0;
    int passes = 0;

    fp_calc_sequencer #(.TIMEOUT_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .in1         (in1),
        .in2         (in2),
        .unit_start  (unit_start),
        .unit_op     (unit_op),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_done   (unit_done),
        .unit_result (unit_result),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .err         (err),
        .timeout     (timeout)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] time limit");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passes++;
        checks++; if (unit_start !== 1'b0) $display("[TB] FAIL reset_unit_start: got %b expected 0", unit_start); else passes++;
        checks++; if ({err, timeout} !== 2'b00) $display("[TB] FAIL reset_flags: got %b expected 00", {err, timeout}); else passes++;
        checks++; if (result !== 32'd0) $display("[TB] FAIL reset_result: got %h expected 0", result); else passes++;
        checks++; if ({unit_op, unit_a, unit_b} !== 67'd0) $display("[TB] FAIL reset_unit_regs: got %h expected 0", {unit_op, unit_a, unit_b}); else passes++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // 2.0 * 3.0 with the unit answering two cycles after its launch pulse.
    task automatic test_mult();
        op = 3'b001; in1 = 32'h4000_0000; in2 = 32'h4040_0000; start = 1'b1;
        @(negedge clk);
        checks++; if (unit_start !== 1'b1) $display("[TB] FAIL mult_unit_start: got %b expected 1", unit_start); else passes++;
        checks++; if (unit_op !== 3'b001) $display("[TB] FAIL mult_unit_op: got %b expected 001", unit_op); else passes++;
        checks++; if (unit_b !== 32'h4040_0000) $display("[TB] FAIL mult_unit_b: got %h expected 40400000", unit_b); else passes++;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL mult_busy: got %b expected 1", busy); else passes++;
        start = 1'b0; in1 = 32'd0; in2 = 32'd0;
        @(negedge clk);
        checks++; if (unit_start !== 1'b0) $display("[TB] FAIL mult_unit_start_pulse: got %b expected 0", unit_start); else passes++;
        checks++; if (unit_a !== 32'h4000_0000) $display("[TB] FAIL mult_unit_a_held: got %h expected 40000000", unit_a); else passes++;
        @(negedge clk);
        unit_done = 1'b1; unit_result = 32'h40C0_0000;
        @(negedge clk);
        unit_done = 1'b0; unit_result = 32'hDEAD_BEEF;
        checks++; if (done !== 1'b1) $display("[TB] FAIL mult_done: got %b expected 1", done); else passes++;
        checks++; if (result !== 32'h40C0_0000) $display("[TB] FAIL mult_result: got %h expected 40c00000", result); else passes++;
        checks++; if ({err, timeout} !== 2'b00) $display("[TB] FAIL mult_flags: got %b expected 00", {err, timeout}); else passes++;
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) $display("[TB] FAIL mult_idle: got %b expected 00", {busy, done}); else passes++;
        checks++; if (result !== 32'h40C0_0000) $display("[TB] FAIL mult_result_held: got %h expected 40c00000", result); else passes++;
    endtask

    // Opcode 110 completes on the next cycle without launching the unit.
    task automatic test_illegal();
        op = 3'b110; in1 = 32'h3F80_0000; in2 = 32'h3F80_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1) $display("[TB] FAIL illegal_done: got %b expected 1", done); else passes++;
        checks++; if (unit_start !== 1'b0) $display("[TB] FAIL illegal_unit_start: got %b expected 0", unit_start); else passes++;
        checks++; if (result !== 32'h7FFF_FFFF) $display("[TB] FAIL illegal_result: got %h expected 7fffffff", result); else passes++;
        checks++; if ({err, timeout} !== 2'b10) $display("[TB] FAIL illegal_flags: got %b expected 10", {err, timeout}); else passes++;
        @(negedge clk);
        checks++; if ({busy, done, unit_start} !== 3'b000) $display("[TB] FAIL illegal_idle: got %b expected 000", {busy, done, unit_start}); else passes++;
    endtask

    // No unit answer: four WAIT cycles, then abort.
    task automatic test_timeout();
        op = 3'b000; in1 = 32'h3F80_0000; in2 = 32'h3F80_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (err !== 1'b0) $display("[TB] FAIL timeout_err_cleared: got %b expected 0", err); else passes++;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            checks++; if ({busy, done} !== 2'b10) $display("[TB] FAIL timeout_wait_%0d: got busy,done %b expected 10", c, {busy, done}); else passes++;
        end
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("[TB] FAIL timeout_done: got %b expected 1", done); else passes++;
        checks++; if ({err, timeout} !== 2'b01) $display("[TB] FAIL timeout_flags: got %b expected 01", {err, timeout}); else passes++;
        checks++; if (result !== 32'h7FFF_FFFF) $display("[TB] FAIL timeout_result: got %h expected 7fffffff", result); else passes++;
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) $display("[TB] FAIL timeout_idle: got %b expected 00", {busy, done}); else passes++;
    endtask

    // Unit answers in the last WAIT cycle: the answer beats the watchdog.
    task automatic test_race();
        op = 3'b011; in1 = 32'h4180_0000; in2 = 32'h4000_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (timeout !== 1'b0) $display("[TB] FAIL race_timeout_cleared: got %b expected 0", timeout); else passes++;
        repeat (4) @(negedge clk);
        unit_done = 1'b1; unit_result = 32'h4080_0000;
        @(negedge clk);
        unit_done = 1'b0;
        checks++; if (done !== 1'b1) $display("[TB] FAIL race_done: got %b expected 1", done); else passes++;
        checks++; if (timeout !== 1'b0) $display("[TB] FAIL race_timeout: got %b expected 0", timeout); else passes++;
        checks++; if (result !== 32'h4080_0000) $display("[TB] FAIL race_result: got %h expected 40800000", result); else passes++;
        @(negedge clk);
    endtask

    // start held high for two full requests, unit answering in WAIT cycle 3.
    task automatic test_back_to_back();
        logic exp_us, exp_done, exp_busy;
        op = 3'b001; in1 = 32'h4000_0000; in2 = 32'h4040_0000; start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            exp_us   = (c == 1) || (c == 7);
            exp_done = (c == 5) || (c == 11);
            exp_busy = !((c == 6) || (c == 12) || (c == 13));
            checks++; if (unit_start !== exp_us) $display("[TB] FAIL b2b_unit_start_c%0d: got %b expected %b", c, unit_start, exp_us); else passes++;
            checks++; if (done !== exp_done) $display("[TB] FAIL b2b_done_c%0d: got %b expected %b", c, done, exp_done); else passes++;
            checks++; if (busy !== exp_busy) $display("[TB] FAIL b2b_busy_c%0d: got %b expected %b", c, busy, exp_busy); else passes++;
            unit_done   = (c == 4) || (c == 10);
            unit_result = (c == 4) ? 32'h40C0_0000 : 32'h4110_0000;
            if (c == 12) start = 1'b0;
        end
        checks++; if (result !== 32'h4110_0000) $display("[TB] FAIL b2b_result: got %h expected 41100000", result); else passes++;
    endtask

    // NaN first operand for div: bypassed only when the feature is built in.
    task automatic test_nan();
        op = 3'b010; in1 = 32'h7FC0_0000; in2 = 32'h3F80_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef FP_SEQ_NAN_BYPASS_EN
        checks++; if (done !== 1'b1) $display("[TB] FAIL nan_done: got %b expected 1", done); else passes++;
        checks++; if (unit_start !== 1'b0) $display("[TB] FAIL nan_unit_start: got %b expected 0", unit_start); else passes++;
        checks++; if (result !== 32'h7FFF_FFFF) $display("[TB] FAIL nan_result: got %h expected 7fffffff", result); else passes++;
        checks++; if (err !== 1'b0) $display("[TB] FAIL nan_err: got %b expected 0", err); else passes++;
        @(negedge clk);
`else
        checks++; if (unit_start !== 1'b1) $display("[TB] FAIL nan_unit_start: got %b expected 1", unit_start); else passes++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL nan_done_early: got %b expected 0", done); else passes++;
        @(negedge clk);
        unit_done = 1'b1; unit_result = 32'h7FC0_0000;
        @(negedge clk);
        unit_done = 1'b0;
        checks++; if (done !== 1'b1) $display("[TB] FAIL nan_done: got %b expected 1", done); else passes++;
        checks++; if (result !== 32'h7FC0_0000) $display("[TB] FAIL nan_result: got %h expected 7fc00000", result); else passes++;
        @(negedge clk);
`endif
        checks++; if (busy !== 1'b0) $display("[TB] FAIL nan_idle: got %b expected 0", busy); else passes++;
    endtask

    // Reset during WAIT, then a stray unit answer that must be ignored.
    task automatic test_reset_mid_wait();
        op = 3'b000; in1 = 32'h3F80_0000; in2 = 32'h4000_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rstwait_busy: got %b expected 0", busy); else passes++;
        unit_done = 1'b1; unit_result = 32'h1234_5678;
        @(negedge clk);
        unit_done = 1'b0;
        checks++; if ({busy, done} !== 2'b00) $display("[TB] FAIL rstwait_after_done: got %b expected 00", {busy, done}); else passes++;
        checks++; if (result !== 32'd0) $display("[TB] FAIL rstwait_result: got %h expected 0", result); else passes++;
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) $display("[TB] FAIL rstwait_settled: got %b expected 00", {busy, done}); else passes++;
        checks++; if (result !== 32'd0) $display("[TB] FAIL rstwait_result_held: got %h expected 0", result); else passes++;
    endtask

    // Scenario sequence.
    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; in1 = 32'd0; in2 = 32'd0;
        unit_done = 1'b0; unit_result = 32'd0;
        $display("[TB] fp_calc_sequencer directed test start");
        test_reset();
        test_mult();
        test_illegal();
        test_timeout();
        test_race();
        test_back_to_back();
        test_nan();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
